test_status_monitor: RTL
========================

# test_status_monitor

Synthesizable on-chip monitor for the self-test status bus that firmware drives on the upper user GPIOs (error flag plus stage code). It replaces the simulation-only watcher with a parametrised, clocked block. The block samples the bus at a fixed divided rate, records every stage transition with a sample timestamp in a small FIFO, and latches one of three terminal verdicts: pass, fail or timeout. It sits in the user project next to the unit under test, and its verdict and log are readable by Wishbone glue.

## Interface
- STAGE_W, 5: width of the stage code.
- SAMPLE_DIV, 24: clock cycles per status sample. Must be ≥ 2.
- TIMEOUT_SAMPLES, 96000: samples taken before timeout. Must be ≥ 1 and < 2^32.
- PASS_CODE, 30: stage code that signals pass.
- LOG_DEPTH, 8: number of transition-log entries. Must be a power of 2 and ≥ 2.
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  run request. 0 forces IDLE.
- status_i  in  STAGE_W+1  bit [STAGE_W] is the error flag; bits [STAGE_W-1:0] are the stage code.
- busy_o  out  1  high while in state RUN.
- pass_o / fail_o / timeout_o  out  1 each  terminal verdicts. They are mutually exclusive.
- cur_stage_o  out  STAGE_W  last sampled stage code. In FAIL it holds the stage captured at the error.
- log_data_o  out  STAGE_W+16  FIFO head, first-word-fall-through: {stage, timestamp[15:0]}.
- log_valid_o  out  1  FIFO not empty.
- log_rd_i  in  1  pop the FIFO head.
- log_ovf_o  out  1  sticky flag: a push was dropped because the FIFO was full.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- IDLE → RUN when en_i=1. On entry, clear the divider, the sample counter (32 bits), last_stage (set to 0), the FIFO and log_ovf_o.
- Tick: a tick occurs in RUN when the divider equals SAMPLE_DIV-1. The divider wraps to 0 on a tick. Let k be the value of the sample counter before it increments.
- At a tick, resolve in this priority order:
  1. Error flag = 1 → FAIL. Capture the stage. No log push.
  2. Otherwise, if stage ≠ last_stage → push {stage, k[15:0]} and update last_stage.
  3. Then, if stage = PASS_CODE → PASS. The push in step 2 still happens when the stage changed.
  4. Otherwise, if k = TIMEOUT_SAMPLES-1 → TIMEOUT.
- Exactly TIMEOUT_SAMPLES samples are evaluated before a timeout.
- Stage code 0 is never logged as the first entry, because last_stage resets to 0.
- PASS, FAIL and TIMEOUT hold until en_i=0, then → IDLE. IDLE clears the verdict flags but keeps the FIFO contents readable.
- en_i=0 while in RUN → IDLE immediately. No verdict is raised.
- FIFO rules:
  - A push into a full FIFO is dropped and sets log_ovf_o.
  - A pop when empty is ignored.
  - A simultaneous push and pop while full succeeds with no overflow.
  - A simultaneous push and pop while empty: the push lands and the pop is ignored.
  - Pointers wrap modulo LOG_DEPTH.
- Reset values: state IDLE; all output flags 0; cur_stage_o = 0; log_data_o = 0 when empty; FIFO empty; log_ovf_o = 0.
- Reset asserted mid-run: all state returns to reset values asynchronously. The log is lost.

## Timing
- All outputs are registered except log_data_o and log_valid_o. Those two are driven from the FIFO memory and pointers.
- Entry into RUN: en_i is sampled high in IDLE at edge e0. busy_o is high after e0.
- The first tick is at edge e0 + SAMPLE_DIV. Tick n is at edge e0 + (n+1)·SAMPLE_DIV.
- status_i is sampled exactly at tick edges. No input synchronizer is included; the upstream logic owns synchronization.
- A verdict flag rises and busy_o falls in the cycle after the deciding tick edge.
- A log push is visible on log_valid_o and log_data_o in the cycle after the tick edge.
- A pop takes effect on the edge where log_rd_i=1. The next head is presented in the following cycle.
- In IDLE and in the terminal states, the divider and the sample counter are frozen.

## Test plan
Bench parameters for all scenarios: SAMPLE_DIV=4, TIMEOUT_SAMPLES=16, LOG_DEPTH=4, PASS_CODE=30.

- Normal pass: en_i=1; status drives stage 31 for samples 0–1, then 0, 1, 2 (two samples each), then 30.
  → Log holds {31,0}, {0,2}, {1,4}, {2,6}, then {30,8} is dropped and log_ovf_o=1.
  → pass_o rises at edge e0+36+1. busy_o falls at the same time.
- Error: stage 2 with the error flag set at sample 3.
  → fail_o=1 and cur_stage_o=2 after tick edge e0+16. No log entry for sample 3.
- Timeout: stage held at 5 throughout.
  → Exactly one log entry {5,0}.
  → timeout_o=1 after tick 15 (edge e0+64). It is not raised at tick 14.
- FIFO: pop every entry while pushes continue.
  → Pop on empty leaves log_valid_o=0.
  → A simultaneous push and pop at full gives no overflow and the order is preserved.
- Abort and restart: en_i=0 at e0+10 → IDLE the next cycle with no verdict.
  → Re-enable: the log is cleared and timestamps restart at 0.
- Asynchronous reset: assert wb_rst_i mid-cycle during RUN.
  → All outputs are 0 before the next clock edge. After release, the block sits in IDLE until en_i=1.

Source files
------------

// File: rtl/test_status_monitor.sv
// Clocked monitor for the firmware self-test status bus: samples at a divided
// rate, logs stage transitions with timestamps and latches pass/fail/timeout.
module test_status_monitor #(
  parameter int STAGE_W         = 5,
  parameter int SAMPLE_DIV      = 24,
  parameter int TIMEOUT_SAMPLES = 96000,
  parameter int PASS_CODE       = 30,
  parameter int LOG_DEPTH       = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 en_i,
  input  logic [STAGE_W:0]     status_i,
  output logic                 busy_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [STAGE_W-1:0]   cur_stage_o,
  output logic [STAGE_W+15:0]  log_data_o,
  output logic                 log_valid_o,
  input  logic                 log_rd_i,
  output logic                 log_ovf_o
);

  localparam int AW    = $clog2(LOG_DEPTH);
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int LOG_W = STAGE_W + 16;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q;
  logic [31:0]          cnt_q;
  logic [STAGE_W-1:0]   last_stage_q;
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [LOG_W-1:0]     mem [LOG_DEPTH];

  logic               err_flag;
  logic [STAGE_W-1:0] stage;
  logic               run_active, tick, start;
  logic               stage_chg, is_pass, is_last;
  logic               fifo_empty, fifo_full;
  logic               push, pop, push_ok, drop;

  assign err_flag   = status_i[STAGE_W];
  assign stage      = status_i[STAGE_W-1:0];
  assign run_active = (state_q == S_RUN) && en_i;
  assign tick       = run_active && (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign start      = (state_q == S_IDLE) && en_i;
  assign stage_chg  = (stage != last_stage_q);
  assign is_pass    = (stage == STAGE_W'(PASS_CODE));
  assign is_last    = (cnt_q == 32'(TIMEOUT_SAMPLES - 1));

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = tick && !err_flag && stage_chg;
  assign pop        = log_rd_i && !fifo_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  assign log_valid_o = !fifo_empty;
  assign log_data_o  = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (en_i) state_d = S_RUN;
      S_RUN: begin
        if (!en_i)              state_d = S_IDLE;
        else if (tick) begin
          if (err_flag)         state_d = S_FAIL;
          else if (is_pass)     state_d = S_PASS;
          else if (is_last)     state_d = S_TIMEOUT;
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT: if (!en_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Stage p0: FSM, sampling counters, FIFO pointers and registered flags
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      busy_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      timeout_o    <= 1'b0;
      cur_stage_o  <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      last_stage_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      log_ovf_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_o    <= (state_d == S_RUN);
      pass_o    <= (state_d == S_PASS);
      fail_o    <= (state_d == S_FAIL);
      timeout_o <= (state_d == S_TIMEOUT);
      if (start) begin
        div_q        <= '0;
        cnt_q        <= '0;
        last_stage_q <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        log_ovf_o    <= 1'b0;
      end else begin
        if (tick) begin
          div_q       <= '0;
          cnt_q       <= cnt_q + 32'd1;
          cur_stage_o <= stage;
          if (!err_flag && stage_chg) last_stage_q <= stage;
        end else if (run_active) begin
          div_q <= div_q + DIV_W'(1);
        end
        if (push_ok) wr_ptr_q  <= wr_ptr_q + (AW+1)'(1);
        if (pop)     rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
        if (drop)    log_ovf_o <= 1'b1;
      end
    end
  end

  // Stage p0: log memory write
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= {stage, cnt_q[15:0]};
  end

endmodule
